// File: rtl/softex_lane_dispatch.sv
// -----------------------------------------------------------------------------
// softex_lane_dispatch
//
// Split/merge stage between the wide SoftEx stream FIFOs and NUM_LANES parallel
// datapath lanes. Each accepted wide beat is sliced into per-lane words, which
// are buffered per lane. The lane-enable mask that was active at acceptance is
// recorded in a tag FIFO. Lane results are buffered per lane and reassembled
// in beat order, using only the lanes named in the tag at the head.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   clear_i                 synchronous clear of all state (highest priority)
//   lane_en_i               active-lane mask, sampled on each input handshake
//   in_valid_i/in_ready_o   wide input handshake, in_data_i wide input beat
//   lane_in_valid_o/..._ready_i/..._data_o     per-lane input streams
//   lane_out_valid_i/..._ready_o/..._data_i    per-lane result streams
//   out_valid_o/out_ready_i wide output handshake
//   out_data_o/out_strb_o   reassembled beat and byte strobe of tagged lanes
//   busy_o                  any beat or lane word outstanding
//   err_o                   sticky: a lane returned a result nobody asked for
// -----------------------------------------------------------------------------

// Small first-word-fall-through FIFO; the head word is visible on data_o
// whenever empty_o is low. Push while full and pop while empty are ignored.
module softex_lane_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty_o = (occ_q == '0);
   assign full_o  = (occ_q == OCC_W'(DEPTH));
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      occ_d    = occ_q;
      if (push_ok && !pop_ok) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!push_ok && pop_ok) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage carries no reset: the pointers alone define what is valid.
   always_ff @(posedge clk_i) begin
      if (push_ok && !clear_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end
endmodule

module softex_lane_dispatch #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned LANE_WIDTH = 16,
   parameter int unsigned NUM_LANES  = DATA_WIDTH / LANE_WIDTH,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TAG_DEPTH  = 8,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            clear_i,
   input  logic [NUM_LANES-1:0]            lane_en_i,
   input  logic                            in_valid_i,
   output logic                            in_ready_o,
   input  logic [DATA_WIDTH-1:0]           in_data_i,
   output logic [NUM_LANES-1:0]            lane_in_valid_o,
   input  logic [NUM_LANES-1:0]            lane_in_ready_i,
   output logic [NUM_LANES*LANE_WIDTH-1:0] lane_in_data_o,
   input  logic [NUM_LANES-1:0]            lane_out_valid_i,
   output logic [NUM_LANES-1:0]            lane_out_ready_o,
   input  logic [NUM_LANES*LANE_WIDTH-1:0] lane_out_data_i,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic [DATA_WIDTH-1:0]           out_data_o,
   output logic [DATA_WIDTH/8-1:0]         out_strb_o,
   output logic                            busy_o,
   output logic                            err_o
);
   localparam int unsigned STRB_PER_LANE = LANE_WIDTH / 8;

   logic                            in_fire;
   logic                            out_fire;
   logic                            tag_empty;
   logic                            tag_full;
   logic [NUM_LANES-1:0]            tag_head;
   logic [NUM_LANES-1:0]            in_empty;
   logic [NUM_LANES-1:0]            in_full;
   logic [NUM_LANES-1:0]            out_empty;
   logic [NUM_LANES-1:0]            out_full;
   logic [NUM_LANES*LANE_WIDTH-1:0] out_head;
   logic [NUM_LANES-1:0]            lane_ok;
   logic [NUM_LANES-1:0]            merge_ok;
   logic [NUM_LANES-1:0]            cnt_nz;
   logic [NUM_LANES-1:0]            underflow;
   logic                            err_q;

   // A beat is only accepted when every enabled lane can take its slice and
   // still count it; disabled lanes never hold the beat back.
   assign in_ready_o = (lane_en_i != '0) && !tag_full && (&lane_ok);
   assign in_fire    = in_valid_i && in_ready_o;

   // The head tag names exactly the lanes whose results make up this beat.
   assign out_valid_o = !tag_empty && (&merge_ok);
   assign out_fire    = out_valid_o && out_ready_i;

   softex_lane_fifo #(
      .WIDTH (NUM_LANES),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (in_fire),
      .data_i  (lane_en_i),
      .pop_i   (out_fire),
      .data_o  (tag_head),
      .empty_o (tag_empty),
      .full_o  (tag_full)
   );

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic             in_push;
      logic             lane_in_fire;
      logic             lane_out_fire;
      logic             out_pop;
      logic             dec_ok;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      assign in_push       = in_fire && lane_en_i[gi];
      assign lane_in_fire  = lane_in_valid_o[gi] && lane_in_ready_i[gi];
      assign lane_out_fire = lane_out_valid_i[gi] && lane_out_ready_o[gi];
      assign out_pop       = out_fire && tag_head[gi];

      softex_lane_fifo #(
         .WIDTH (LANE_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) u_in_fifo (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .clear_i (clear_i),
         .push_i  (in_push),
         .data_i  (in_data_i[gi*LANE_WIDTH +: LANE_WIDTH]),
         .pop_i   (lane_in_fire),
         .data_o  (lane_in_data_o[gi*LANE_WIDTH +: LANE_WIDTH]),
         .empty_o (in_empty[gi]),
         .full_o  (in_full[gi])
      );

      softex_lane_fifo #(
         .WIDTH (LANE_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) u_out_fifo (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .clear_i (clear_i),
         .push_i  (lane_out_fire),
         .data_i  (lane_out_data_i[gi*LANE_WIDTH +: LANE_WIDTH]),
         .pop_i   (out_pop),
         .data_o  (out_head[gi*LANE_WIDTH +: LANE_WIDTH]),
         .empty_o (out_empty[gi]),
         .full_o  (out_full[gi])
      );

      assign lane_in_valid_o[gi]  = !in_empty[gi];
      assign lane_out_ready_o[gi] = !out_full[gi];

      // A result with nothing outstanding is flagged and the counter is held
      // at zero instead of wrapping; the word itself is still buffered.
      assign underflow[gi] = lane_out_fire && (cnt_q == '0);
      assign dec_ok        = lane_out_fire && (cnt_q != '0);

      always_comb begin
         cnt_d = cnt_q;
         if (in_push && !dec_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else if (!in_push && dec_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q <= '0;
         end else if (clear_i) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cnt_nz[gi]   = (cnt_q != '0);
      assign lane_ok[gi]  = !lane_en_i[gi] || (!in_full[gi] && (cnt_q != '1));
      assign merge_ok[gi] = !tag_head[gi] || !out_empty[gi];

      assign out_data_o[gi*LANE_WIDTH +: LANE_WIDTH] =
         tag_head[gi] ? out_head[gi*LANE_WIDTH +: LANE_WIDTH] : '0;
      assign out_strb_o[gi*STRB_PER_LANE +: STRB_PER_LANE] = {STRB_PER_LANE{tag_head[gi]}};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (clear_i) begin
         err_q <= 1'b0;
      end else if (|underflow) begin
         err_q <= 1'b1;
      end
   end

   assign err_o  = err_q;
   assign busy_o = !tag_empty || (|cnt_nz) || !(&in_empty);
endmodule

// File: tb/tb_softex_lane_dispatch.sv
module tb_softex_lane_dispatch;
   localparam int DW = 256;
   localparam int LW = 16;
   localparam int NL = 16;
   localparam int SW = DW / 8;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic              rst_ni, clear_i;
   logic [NL-1:0]     lane_en_i;
   logic              in_valid_i, in_ready_o;
   logic [DW-1:0]     in_data_i;
   logic [NL-1:0]     lane_in_valid_o, lane_in_ready_i;
   logic [NL*LW-1:0]  lane_in_data_o;
   logic [NL-1:0]     lane_out_valid_i, lane_out_ready_o;
   logic [NL*LW-1:0]  lane_out_data_i;
   logic              out_valid_o, out_ready_i;
   logic [DW-1:0]     out_data_o;
   logic [SW-1:0]     out_strb_o;
   logic              busy_o, err_o;

   softex_lane_dispatch dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .clear_i          (clear_i),
      .lane_en_i        (lane_en_i),
      .in_valid_i       (in_valid_i),
      .in_ready_o       (in_ready_o),
      .in_data_i        (in_data_i),
      .lane_in_valid_o  (lane_in_valid_o),
      .lane_in_ready_i  (lane_in_ready_i),
      .lane_in_data_o   (lane_in_data_o),
      .lane_out_valid_i (lane_out_valid_i),
      .lane_out_ready_o (lane_out_ready_o),
      .lane_out_data_i  (lane_out_data_i),
      .out_valid_o      (out_valid_o),
      .out_ready_i      (out_ready_i),
      .out_data_o       (out_data_o),
      .out_strb_o       (out_strb_o),
      .busy_o           (busy_o),
      .err_o            (err_o)
   );

   typedef struct packed { logic [DW-1:0] d; logic [NL-1:0] m; } beat_t;
   typedef struct packed { logic [DW-1:0] d; logic [SW-1:0] s; } exp_t;

   // Reference model: offered beats, expected wide outputs in order, and an
   // echoing datapath per lane (a plain word queue).
   beat_t         pend_q[$];
   exp_t          exp_q[$];
   logic [LW-1:0] lane_q [NL][$];
   logic [SW-1:0] strb_log[$];

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int out_cnt = 0;
   int out_base;
   logic [NL-1:0] idle_mask, acc_en, ret_en;
   bit rnd_lane, rnd_out, inject;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t expect_of(beat_t b);
      exp_t e;
      e.d = '0;
      e.s = '0;
      for (int i = 0; i < NL; i++) begin
         if (b.m[i]) begin
            e.d[i*LW +: LW] = b.d[i*LW +: LW];
            e.s[i*2 +: 2]   = 2'b11;
         end
      end
      return e;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] r;
      for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic drive_in();
      if (pend_q.size() > 0) begin
         in_valid_i = 1'b1;
         in_data_i  = pend_q[0].d;
         lane_en_i  = pend_q[0].m;
      end else begin
         in_valid_i = 1'b0;
         in_data_i  = '0;
         lane_en_i  = idle_mask;
      end
   endtask

   task automatic offer(input logic [DW-1:0] d, input logic [NL-1:0] m);
      beat_t b;
      b.d = d;
      b.m = m;
      pend_q.push_back(b);
      drive_in();
   endtask

   // One clock: sample handshakes on the falling edge, update the model after
   // the rising edge, then drive the next inputs.
   task automatic cycle();
      logic fin, fout, discard, inj_s;
      logic [NL-1:0] lif, lof;
      logic [NL*LW-1:0] li_snap;
      exp_t e;
      @(negedge clk_i);
      fin     = in_valid_i && in_ready_o;
      fout    = out_valid_o && out_ready_i;
      lif     = lane_in_valid_o & lane_in_ready_i;
      lof     = lane_out_valid_i & lane_out_ready_o;
      li_snap = lane_in_data_o;
      discard = clear_i || !rst_ni;
      inj_s   = inject;
      if (fout && !discard) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", out_data_o, 'x);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data_o, e.d);
            chk("out_strb", {{(DW-SW){1'b0}}, out_strb_o}, {{(DW-SW){1'b0}}, e.s});
            strb_log.push_back(out_strb_o);
            out_cnt++;
            $display("beat %0d out strb=%h data=%h", out_cnt, out_strb_o, out_data_o);
         end
      end
      @(posedge clk_i);
      #1;
      if (discard) begin
         pend_q.delete();
         exp_q.delete();
         for (int i = 0; i < NL; i++) lane_q[i].delete();
         inject = 1'b0;
      end else begin
         if (fin) begin
            exp_q.push_back(expect_of(pend_q.pop_front()));
            acc_cnt++;
         end
         for (int i = 0; i < NL; i++) begin
            if (lif[i]) lane_q[i].push_back(li_snap[i*LW +: LW]);
            if (lof[i]) begin
               if (i == 3 && inj_s) inject = 1'b0;
               else if (lane_q[i].size() > 0) void'(lane_q[i].pop_front());
            end
         end
      end
      drive_in();
      for (int i = 0; i < NL; i++) begin
         lane_in_ready_i[i] = acc_en[i] && (!rnd_lane || ($urandom_range(0, 1) == 1));
         if (discard || !(lane_out_valid_i[i] && !lof[i]))
            lane_out_valid_i[i] = (lane_q[i].size() > 0) && ret_en[i] &&
                                  (!rnd_lane || ($urandom_range(0, 1) == 1));
         lane_out_data_i[i*LW +: LW] = (lane_q[i].size() > 0) ? lane_q[i][0] : '0;
      end
      if (inject) begin
         lane_out_valid_i[3]         = 1'b1;
         lane_out_data_i[3*LW +: LW] = 16'hDEAD;
      end
      out_ready_i = !rnd_out || ($urandom_range(0, 1) == 1);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((pend_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
         cycle();
         n++;
      end
      chk({tag, "_drain_in_budget"}, DW'(n < budget), DW'(1));
   endtask

   initial begin
      logic [DW-1:0] d;
      rst_ni = 1'b0;  clear_i = 1'b0;
      idle_mask = '1; acc_en = '1; ret_en = '1;
      rnd_lane = 1'b0; rnd_out = 1'b0; inject = 1'b0;
      lane_in_ready_i = '0; lane_out_valid_i = '0; lane_out_data_i = '0;
      out_ready_i = 1'b1;
      drive_in();
      #2;
      // Reset state
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_lane_in_valid", lane_in_valid_o, 0);
      chk("rst_lane_out_ready", lane_out_ready_o, 16'hFFFF);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_in_ready_mask_on", in_ready_o, 1);
      idle_mask = '0;
      drive_in();
      #1;
      chk("rst_in_ready_mask_off", in_ready_o, 0);
      idle_mask = '1;
      drive_in();
      run(2);
      rst_ni = 1'b1;
      run(1);

      // 1: single full-width beat echoes back unchanged
      d = '0;
      for (int i = 0; i < NL; i++) d[i*LW +: LW] = LW'(i + 1);
      out_base = out_cnt;
      offer(d, 16'hFFFF);
      drain("t1", 50);
      chk("t1_count", out_cnt - out_base, 1);
      run(2);
      chk("t1_busy_after", busy_o, 0);

      // 2: lower-half beat then upper-half beat, upper lanes answer first
      strb_log.delete();
      ret_en = 16'hFF00;
      offer(rand_data(), 16'h00FF);
      offer(rand_data(), 16'hFF00);
      run(12);
      chk("t2_head_blocked", out_valid_o, 0);
      ret_en = '1;
      drain("t2", 100);
      chk("t2_count", strb_log.size(), 2);
      if (strb_log.size() >= 2) begin
         chk("t2_first_strb", strb_log[0], 32'h0000FFFF);
         chk("t2_second_strb", strb_log[1], 32'hFFFF0000);
      end

      // 3: lanes refuse input; only the lane input FIFOs' worth is accepted
      acc_en = '0;
      acc_cnt = 0;
      out_base = out_cnt;
      for (int k = 0; k < 12; k++) offer(rand_data(), 16'hFFFF);
      run(20);
      chk("t3_accepted", acc_cnt, 4);
      chk("t3_in_ready", in_ready_o, 0);
      acc_en = '1;
      drain("t3", 400);
      chk("t3_count", out_cnt - out_base, 12);

      // 4: lane 5 silent; the tag FIFO bounds beats in flight
      ret_en = ~16'h0020;
      acc_cnt = 0;
      out_base = out_cnt;
      for (int k = 0; k < 12; k++) offer(rand_data(), 16'hFFFF);
      run(40);
      chk("t4_accepted", acc_cnt, 8);
      chk("t4_in_ready", in_ready_o, 0);
      chk("t4_out_valid", out_valid_o, 0);
      ret_en = '1;
      drain("t4", 500);
      chk("t4_count", out_cnt - out_base, 12);

      // Random masks, data and back-pressure against the scoreboard
      rnd_lane = 1'b1;
      rnd_out = 1'b1;
      out_base = out_cnt;
      for (int k = 0; k < 80; k++)
         offer(rand_data(), NL'($urandom_range(1, 16'hFFFF)));
      drain("rand", 4000);
      chk("rand_count", out_cnt - out_base, 80);
      rnd_lane = 1'b0;
      rnd_out = 1'b0;
      run(4);
      chk("rand_busy_after", busy_o, 0);

      // 5: empty mask never accepts; unsolicited result sets sticky error
      acc_cnt = 0;
      offer(rand_data(), 16'h0000);
      run(5);
      chk("t5_in_ready", in_ready_o, 0);
      chk("t5_no_tag_busy", busy_o, 0);
      chk("t5_accepted", acc_cnt, 0);
      pend_q.delete();
      drive_in();
      chk("t5_err_before", err_o, 0);
      inject = 1'b1;
      run(2);
      chk("t5_err_set", err_o, 1);
      chk("t5_busy_no_wrap", busy_o, 0);
      run(5);
      chk("t5_err_sticky", err_o, 1);

      // 6: clear and mid-flight reset both discard everything
      ret_en = '0;
      for (int k = 0; k < 3; k++) offer(rand_data(), 16'hFFFF);
      run(8);
      chk("t6_busy_before_clear", busy_o, 1);
      clear_i = 1'b1;
      run(1);
      clear_i = 1'b0;
      chk("t6_clr_out_valid", out_valid_o, 0);
      chk("t6_clr_busy", busy_o, 0);
      chk("t6_clr_err", err_o, 0);
      for (int k = 0; k < 2; k++) offer(rand_data(), 16'hFFFF);
      run(6);
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_out_valid", out_valid_o, 0);
      chk("t6_rst_lane_in_valid", lane_in_valid_o, 0);
      chk("t6_rst_lane_out_ready", lane_out_ready_o, 16'hFFFF);
      chk("t6_rst_busy", busy_o, 0);
      run(1);
      rst_ni = 1'b1;
      ret_en = '1;
      run(3);
      chk("t6_rst_no_output", out_valid_o, 0);
      chk("t6_rst_err", err_o, 0);
      out_base = out_cnt;
      offer(rand_data(), 16'h5A3C);
      drain("t6", 50);
      chk("t6_fresh_count", out_cnt - out_base, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
